// File: rtl/imag2real.sv
// Maps a fixed-point complex point back to its 640x480 pixel coordinate.
// The real axis is divided by 7 using a bit-serial restoring divider; the imaginary axis is a shift.
module imag2real #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11,
  parameter int INTEGRAL   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] z_real_in,
  input  logic [WIDTH-1:0] z_imag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       x_out,
  output logic [9:0]       y_out,
  output logic             in_range
);

  localparam int OW    = INTEGRAL + FRACTIONAL + 1;
  localparam int R_LIM = 640 * 7;
  localparam int I_LIM = 480 * 8;
  localparam logic [OW-1:0] ONE = OW'(1 << FRACTIONAL);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [12:0] dividend_q, dividend_d;
  logic [9:0]  ybuf_q, ybuf_d;
  logic [2:0]  rem_q, rem_d;
  logic [9:0]  quot_q, quot_d;
  logic [3:0]  count_q, count_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        inr_q, inr_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic [OW-1:0] off_r, off_i;
  logic          r_ok, i_ok;
  logic [3:0]    rem_ext;
  logic          q_bit;
  logic [2:0]    rem_nxt;
  logic [9:0]    quot_nxt;

  // Sign-extend by one bit so the largest positive input cannot wrap.
  always_comb begin
    off_r = {z_real_in[WIDTH-1], z_real_in} + ONE;
    off_i = {z_imag_in[WIDTH-1], z_imag_in} + ONE;
    r_ok  = !off_r[OW-1] && (off_r < OW'(R_LIM));
    i_ok  = !off_i[OW-1] && (off_i < OW'(I_LIM));
  end

  // Quotient keeps only 10 bits: the range check guarantees the upper bits are zero.
  always_comb begin
    rem_ext  = {rem_q, dividend_q[count_q]};
    q_bit    = (rem_ext >= 4'd7);
    rem_nxt  = q_bit ? 3'(rem_ext - 4'd7) : rem_ext[2:0];
    quot_nxt = {quot_q[8:0], q_bit};
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    ybuf_d     = ybuf_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    count_d    = count_q;
    x_d        = x_q;
    y_d        = y_q;
    inr_d      = inr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (r_ok && i_ok) begin
            dividend_d = off_r[12:0];
            ybuf_d     = off_i[12:3];
            rem_d      = '0;
            quot_d     = '0;
            count_d    = 4'd12;
            state_d    = DIV;
          end else begin
            x_d     = '0;
            y_d     = '0;
            inr_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DIV: begin
        rem_d  = rem_nxt;
        quot_d = quot_nxt;
        if (count_q == 4'd0) begin
          x_d     = quot_nxt;
          y_d     = ybuf_q;
          inr_d   = 1'b1;
          state_d = DONE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      ybuf_q      <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      count_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      inr_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      ybuf_q      <= ybuf_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      count_q     <= count_d;
      x_q         <= x_d;
      y_q         <= y_d;
      inr_q       <= inr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign in_range  = inr_q;

endmodule
